// File: rtl/cp0_unit_if.sv
// Bus between the multicycle control FSM and the CP0 register file:
// strobes and write data flow into CP0; read data, EPC and intreq flow back.
interface cp0_unit_if;
  logic [4:0]  sel;
  logic [31:0] din;
  logic        wen;
  logic [29:0] pc;
  logic        epcwr;
  logic        exlset;
  logic        exlclr;
  logic [5:0]  hwint;
  logic [31:0] dout;
  logic [29:0] epc;
  logic        intreq;

  modport master (
    output sel, din, wen, pc, epcwr, exlset, exlclr, hwint,
    input  dout, epc, intreq
  );

  modport slave (
    input  sel, din, wen, pc, epcwr, exlset, exlclr, hwint,
    output dout, epc, intreq
  );
endinterface

// File: rtl/cp0_unit.sv
// Coprocessor-0 register file: SR, Cause, EPC, PrID and a Count/Compare timer
// whose interrupt is merged onto hardware interrupt line 5.
module cp0_unit #(
  parameter logic [31:0] PRID     = 32'h0000_4D50,
  parameter bit          TIMER_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  cp0_unit_if.slave   bus
);

  logic [5:0]  r_im;
  logic [5:0]  r_ip;
  logic        r_exl;
  logic        r_ie;
  logic        r_ti;
  logic [29:0] r_epc;
  logic [31:0] r_count;
  logic [31:0] r_compare;

  logic w_sr_wr;
  logic w_epc_wr;
  logic w_count_wr;
  logic w_cmp_wr;

  assign w_sr_wr    = bus.wen && (bus.sel == 5'd12);
  assign w_epc_wr   = bus.wen && (bus.sel == 5'd14);
  assign w_count_wr = bus.wen && (bus.sel == 5'd9);
  assign w_cmp_wr   = bus.wen && (bus.sel == 5'd11);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_im      <= '0;
      r_ie      <= 1'b0;
      r_exl     <= 1'b0;
      r_ip      <= '0;
      r_epc     <= '0;
      r_compare <= '0;
    end else begin
      // Interrupt entry beats eret, and both beat a software SR write.
      if (bus.exlset)
        r_exl <= 1'b1;
      else if (bus.exlclr)
        r_exl <= 1'b0;
      else if (w_sr_wr)
        r_exl <= bus.din[1];

      if (w_sr_wr) begin
        r_im <= bus.din[15:10];
        r_ie <= bus.din[0];
      end

      if (bus.epcwr)
        r_epc <= bus.pc;
      else if (w_epc_wr)
        r_epc <= bus.din[31:2];

      r_ip <= {bus.hwint[5] | r_ti, bus.hwint[4:0]};

      if (w_cmp_wr)
        r_compare <= bus.din;
    end
  end

  generate
    if (TIMER_EN) begin : g_timer
      always_ff @(posedge clk) begin
        if (rst) begin
          r_count <= '0;
          r_ti    <= 1'b0;
        end else begin
          r_count <= w_count_wr ? bus.din : r_count + 32'd1;
          // Match uses the pre-edge Count; a Compare write clears and wins.
          if (w_cmp_wr)
            r_ti <= 1'b0;
          else if ((r_count == r_compare) && (r_compare != 32'd0))
            r_ti <= 1'b1;
        end
      end
    end else begin : g_no_timer
      always_ff @(posedge clk) begin
        r_count <= '0;
        r_ti    <= 1'b0;
      end
    end
  endgenerate

  always_comb begin
    bus.dout = '0;
    case (bus.sel)
      5'd9:    bus.dout = r_count;
      5'd11:   bus.dout = r_compare;
      5'd12:   bus.dout = {16'b0, r_im, 8'b0, r_exl, r_ie};
      5'd13:   bus.dout = {1'b0, r_ti, 14'b0, r_ip, 10'b0};
      5'd14:   bus.dout = {r_epc, 2'b00};
      5'd15:   bus.dout = PRID;
      default: bus.dout = '0;
    endcase
  end

  assign bus.epc    = r_epc;
  assign bus.intreq = (|(r_ip & r_im)) & r_ie & ~r_exl;

endmodule

// File: doc/cp0_unit.md
Name: cp0_unit

Overview:
- Coprocessor-0 register file for the multicycle MIPS core. It sits directly beside the control FSM.
- It consumes the FSM's wen/epcwr/exlset/exlclr strobes, which are driven by mtc0, the interrupt-entry state and eret.
- It produces intreq, sampled by the FSM at instruction-end states, and the EPC value used by npc for eret.
- It also hosts SR, Cause, EPC, PrID and a Count/Compare timer whose interrupt merges into hardware line 5.

Parameters:
PRID, 32'h0000_4D50, constant value returned on reads of register 15
TIMER_EN, 1, 1 = Count/Compare timer present; 0 = Count holds 0 and TI never sets

Ports:
clk  in  1  system clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
sel  in  5  CP0 register number (instr rd field) for read and write
din  in  32  write data (GPR rt) for mtc0
wen  in  1  mtc0 write strobe
pc  in  30  PC[31:2] to save on interrupt entry
epcwr  in  1  save pc into EPC
exlset  in  1  set SR.EXL (interrupt entry)
exlclr  in  1  clear SR.EXL (eret)
hwint  in  6  external device interrupt lines, level-sensitive, active-high
dout  out  32  combinational read of register sel (mfc0)
epc  out  30  EPC[31:2] for eret target
intreq  out  1  interrupt request to control FSM

Behaviour:
- Reset (rst high at posedge):
  - IM=0, EXL=0, IE=0, IP=0, EPC=0, Count=0, Compare=0, TI=0.
  - intreq=0 and epc=0 from the next cycle.
  - Reset overrides every strobe in that cycle.
- Register map and read formats (dout, sel decode is combinational):
  - 9 Count = {Count}.
  - 11 Compare = {Compare}.
  - 12 SR = {16'b0, IM[15:10], 8'b0, EXL, IE}.
  - 13 Cause = {1'b0, TI, 14'b0, IP[15:10], 10'b0}.
  - 14 EPC = {epc, 2'b00}.
  - 15 PrID = PRID.
  - All other sel values read 0.
- Writes (wen=1):
  - sel 12 loads IM=din[15:10], EXL=din[1], IE=din[0].
  - sel 14 loads EPC=din[31:2].
  - sel 9 loads Count=din.
  - sel 11 loads Compare=din and clears TI.
  - Writes to 13, 15 and unmapped sel are ignored.
- IP: registered every cycle. IP[14:10]<=hwint[4:0]; IP[15]<=hwint[5]|TI. This gives one cycle of latency from hwint to intreq.
- intreq = |(IP & IM) & IE & ~EXL. It is combinational from registers, so glitch-free per cycle.
- EXL priority, same cycle:
  - exlset > exlclr > mtc0 SR write.
  - IM/IE from an mtc0 SR write still take effect in that cycle.
- EPC priority: epcwr > mtc0 EPC write. epcwr stores pc as presented (already the next-instruction PC).
- Timer (TIMER_EN=1):
  - Count increments by 1 each cycle, wrapping 32'hFFFF_FFFF -> 0.
  - An mtc0 Count write replaces the increment for that cycle.
  - TI is set at the edge where the old Count == Compare and Compare != 0.
  - A Compare write in the same cycle wins (TI cleared).
  - TI stays set until Compare is written.
- Interrupt sequence with the FSM:
  - intreq is high at an end state; the FSM enters the interrupt state and pulses epcwr+exlset for 1 cycle.
  - The next cycle has EXL=1, so intreq=0 and nesting is blocked.
  - eret pulses exlclr; EXL=0 the next cycle. intreq may reassert immediately if the source is still pending.
- Reset mid-interrupt clears EXL and EPC; no pending state survives.

Test Plan:
- Reset, then read sel 12, 13, 14, 15 → 0, 0, 0, 32'h0000_4D50; intreq=0.
- mtc0 SR din=32'h0000_0401 (IM[10], IE), then hwint=6'b000001:
  - intreq=0 in the hwint cycle and 1 one cycle later.
  - Cause reads 32'h0000_0400.
- With intreq=1, pulse epcwr+exlset with pc=30'h0000_0C05:
  - next cycle EXL=1, intreq=0, EPC read = 32'h0000_3014.
  - Then exlclr → intreq=1 next cycle (hwint still high).
- Same-cycle exlset+exlclr+mtc0 SR din=0:
  - EXL=1, IM=0, IE=0.
  - Same-cycle epcwr pc=30'h1 plus mtc0 EPC din=32'hFFFF_FFFC → EPC=32'h0000_0004.
- Timer:
  - mtc0 Compare=5, SR=32'h0000_8001; Count counts from 0.
  - TI sets at the edge where Count=5, Cause[30]=1; intreq=1 one cycle later.
  - mtc0 Compare=100 → TI=0, and intreq drops one cycle later.
- Count wrap and reset: mtc0 Count=32'hFFFF_FFFF → next cycle 0. Assert rst during EXL=1 → all registers 0 at next edge.
